// File: rtl/sparse_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sparse_pkg: shared constants and types for the 2:4 sparse packer |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package sparse_pkg;

    localparam int GROUP_SIZE = 4;
    localparam int KEEP       = 2;
    localparam int DATA_W     = 8;
    localparam int MAG_W      = 9;
    localparam int IDX_W      = 2;

    localparam logic [GROUP_SIZE-1:0] MASK_NONE     = 4'b0000;
    localparam logic [GROUP_SIZE-1:0] MASK_LOW_PAIR = 4'b0011;

    typedef struct packed {
        logic [GROUP_SIZE-1:0] mask;
        logic [DATA_W-1:0]     weight_top;
        logic [DATA_W-1:0]     weight_bot;
        logic [2*DATA_W-1:0]   acts;
    } packed_group_t;

    // 9-bit result so that |-128| = 128 is representable
    function automatic logic [MAG_W-1:0] magnitude(input logic [DATA_W-1:0] w);
        logic [MAG_W-1:0] ext;
        ext = {w[DATA_W-1], w};
        return w[DATA_W-1] ? (~ext + MAG_W'(1)) : ext;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sparse_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sparse_fifo: synchronous FIFO, power-of-two depth, async reset   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sparse_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= push_data;
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/sparse_24_packer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sparse_24_packer: prunes 4-weight groups to 2:4 and buffers them |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sparse_24_packer
    import sparse_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_weights,
    input  logic [31:0] in_acts,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] packed_activations,
    output logic [3:0]  mask,
    output logic [7:0]  weight_top,
    output logic [7:0]  weight_bot,
    output logic [15:0] groups_out
);
    localparam int c_cnt_w  = $clog2(FIFO_DEPTH) + 1;
    localparam int c_rank_w = $clog2(GROUP_SIZE) + 1;
    localparam int c_grp_w  = $bits(packed_group_t);

    logic                                w_accept;
    logic                                w_pop;
    logic [c_cnt_w-1:0]                  w_count;
    logic                                r_s1_valid;
    logic [GROUP_SIZE-1:0][DATA_W-1:0]   r_s1_w;
    logic [GROUP_SIZE-1:0][DATA_W-1:0]   r_s1_a;
    logic [GROUP_SIZE-1:0][MAG_W-1:0]    r_s1_mag;
    logic [GROUP_SIZE-1:0][c_rank_w-1:0] w_rank;
    logic [GROUP_SIZE-1:0]               w_keep;
    logic [IDX_W-1:0]                    w_top_idx;
    logic [IDX_W-1:0]                    w_bot_idx;
    packed_group_t                       w_s2_group;
    packed_group_t                       w_head;
    logic [15:0]                         r_groups_out;

    // Counting the S1 slot as occupied guarantees the FIFO has room for it
    assign in_ready = (int'(w_count) + int'(r_s1_valid)) < FIFO_DEPTH;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_s1_valid <= 1'b0;
        else        r_s1_valid <= w_accept;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_w <= in_weights;
            r_s1_a <= in_acts;
            for (int i = 0; i < GROUP_SIZE; i++)
                r_s1_mag[i] <= magnitude(in_weights[i*DATA_W +: DATA_W]);
        end
    end

    // Rank = number of entries that beat this one (equal magnitude at a lower index wins)
    always_comb begin
        for (int i = 0; i < GROUP_SIZE; i++) begin
            w_rank[i] = '0;
            for (int j = 0; j < GROUP_SIZE; j++) begin
                if (j != i && (r_s1_mag[j] > r_s1_mag[i] ||
                               (r_s1_mag[j] == r_s1_mag[i] && j < i)))
                    w_rank[i] = w_rank[i] + c_rank_w'(1);
            end
            w_keep[i] = (w_rank[i] < c_rank_w'(KEEP));
        end
    end

    always_comb begin
        w_top_idx = '0;
        w_bot_idx = '0;
        for (int i = GROUP_SIZE - 1; i >= 0; i--)
            if (w_keep[i]) w_top_idx = IDX_W'(i);
        for (int i = 0; i < GROUP_SIZE; i++)
            if (w_keep[i]) w_bot_idx = IDX_W'(i);
    end

    always_comb begin
        w_s2_group.mask       = w_keep;
        w_s2_group.weight_top = r_s1_w[w_top_idx];
        w_s2_group.weight_bot = r_s1_w[w_bot_idx];
        w_s2_group.acts       = {r_s1_a[w_top_idx], r_s1_a[w_bot_idx]};
    end

    sparse_fifo #(
        .WIDTH (c_grp_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (r_s1_valid),
        .push_data (w_s2_group),
        .pop       (w_pop),
        .pop_data  (w_head),
        .count     (w_count)
    );

    assign out_valid = (w_count != '0);
    assign w_pop     = out_valid && out_ready;

    // Outputs read zero whenever nothing is buffered
    assign mask               = out_valid ? w_head.mask       : MASK_NONE;
    assign weight_top         = out_valid ? w_head.weight_top : '0;
    assign weight_bot         = out_valid ? w_head.weight_bot : '0;
    assign packed_activations = out_valid ? w_head.acts       : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_groups_out <= '0;
        else if (w_pop) r_groups_out <= r_groups_out + 16'd1;
    end

    assign groups_out = r_groups_out;

endmodule
`default_nettype wire

// File: tb/tb_sparse_24_packer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sparse_24_packer: scoreboard bench with behavioural model     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_sparse_24_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_weights;
    logic [31:0] in_acts;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] packed_activations;
    logic [3:0]  mask;
    logic [7:0]  weight_top;
    logic [7:0]  weight_bot;
    logic [15:0] groups_out;

    sparse_24_packer #(.FIFO_DEPTH(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_weights         (in_weights),
        .in_acts            (in_acts),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .packed_activations (packed_activations),
        .mask               (mask),
        .weight_top         (weight_top),
        .weight_bot         (weight_bot),
        .groups_out         (groups_out)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [35:0] sb[$];
    int          accepted = 0;
    int          exp_groups = 0;
    logic        rand_ready = 1'b0;
    logic        stall_prev = 1'b0;
    logic [35:0] held;
    wire  [35:0] got = {mask, weight_top, weight_bot, packed_activations};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pick the largest |W| (first on ties), then the largest of the rest
    function automatic logic [35:0] model(input logic [31:0] w, input logic [31:0] a);
        int mag[4];
        int first, second, top, bot;
        logic signed [7:0] s;
        logic [3:0] m;
        for (int i = 0; i < 4; i++) begin
            s = w[i*8 +: 8];
            mag[i] = (s < 0) ? -int'(s) : int'(s);
        end
        first = 0;
        for (int i = 1; i < 4; i++) if (mag[i] > mag[first]) first = i;
        second = -1;
        for (int i = 0; i < 4; i++)
            if (i != first && (second < 0 || mag[i] > mag[second])) second = i;
        top = (first < second) ? first : second;
        bot = (first < second) ? second : first;
        m = '0;
        m[first] = 1'b1;
        m[second] = 1'b1;
        return {m, w[top*8 +: 8], w[bot*8 +: 8], a[top*8 +: 8], a[bot*8 +: 8]};
    endfunction

    function automatic logic [31:0] rand_w();
        logic [7:0] tbl [6];
        logic [31:0] r;
        tbl = '{8'h00, 8'h80, 8'h7F, 8'h81, 8'h01, 8'hFF};
        for (int i = 0; i < 4; i++)
            r[i*8 +: 8] = ($urandom_range(0, 1) == 1) ? tbl[$urandom_range(0, 5)] : 8'($urandom);
        return r;
    endfunction

    // Monitor: acceptance pushes the model result, output handshake pops and compares
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev) check("hold_stable", {27'd0, out_valid, got}, {27'd0, 1'b1, held});
            if (in_valid && in_ready) begin
                sb.push_back(model(in_weights, in_acts));
                accepted++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected no output at %0t", got, $time);
                end else begin
                    check("output_group", got, sb.pop_front());
                    check("groups_out_at_pop", groups_out, exp_groups);
                    exp_groups++;
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = got;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [31:0] w, input logic [31:0] a);
        int n = 0;
        in_weights = w;
        in_acts    = a;
        in_valid   = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready %0b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Latency and data of one group through an empty pipeline
    task automatic send_expect(input string name, input logic [31:0] w, input logic [31:0] a,
                               input logic [35:0] exp);
        send(w, a);
        @(negedge clk);
        check({name, "_early"}, out_valid, 1'b0);
        @(negedge clk);
        check({name, "_valid"}, out_valid, 1'b1);
        check({name, "_data"}, got, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d groups left expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        exp_groups = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_outputs", got, 36'd0);
        check("rst_groups_out", groups_out, 16'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_weights = '0;
        in_acts    = '0;
        out_ready  = 1'b1;
        do_reset();

        send_expect("basic", 32'h7F03F005, 32'h44332211, 36'hA_F0_7F_2244);
        send_expect("ties",  32'h02020202, 32'hDDCCBBAA, 36'h3_02_02_AABB);
        send_expect("mag",   32'h00007F80, 32'h04030201, 36'h3_80_7F_0102);

        // Backpressure: six offers into a stalled output
        do_reset();
        out_ready = 1'b0;
        accepted  = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid   = 1'b1;
            in_weights = rand_w();
            in_acts    = $urandom;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bp_accepted", accepted, 4);
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 1'b0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        check("bp_groups_out", groups_out, 16'd4);

        // Reset with three groups buffered
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(rand_w(), $urandom);
        repeat (2) @(posedge clk);
        #1;
        check("mid_buffered", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        sb.delete();
        exp_groups = 0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_groups_out", groups_out, 16'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("mid_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("mid_no_stale", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;

        // Random traffic with random backpressure
        rand_ready = 1'b1;
        for (int g = 0; g < 10000; g++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(rand_w(), $urandom);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();
        check("rand_groups_out", groups_out, 16'd10000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
